bp_core_lce_req_arbiter: RTL and testbench



---
 rtl/bp_core_lce_req_arbiter_pkg.sv | 12 +
 rtl/bp_core_lce_req_arbiter_if.sv | 12 +
 rtl/bp_core_lce_req_arb_buffer.sv | 41 ++++
 rtl/bp_core_lce_req_arbiter.sv | 88 ++++++++
 tb/tb_bp_core_lce_req_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_core_lce_req_arbiter_pkg.sv
// Shared constants and the round-robin pick for the core LCE request arbiter.
package bp_core_lce_req_arbiter_pkg;

   localparam int lce_req_num_gp = 2;

   // With both eligible, favour the requester not served last; otherwise pass the lone one.
   function automatic logic [1:0] rr_grant(input logic [1:0] elig, input logic last);
      if (&elig) return last ? 2'b01 : 2'b10;
      return elig;
   endfunction

endpackage

// File: rtl/bp_core_lce_req_arbiter_if.sv
// Outbound merged LCE request link (valid-then-ready) with source tag.
interface bp_core_lce_req_arbiter_if #(parameter int width_p = 1);

   logic [width_p-1:0] req;
   logic               req_v;
   logic               req_ready;
   logic               req_src;

   modport master (output req, output req_v, output req_src, input req_ready);
   modport slave  (input req, input req_v, input req_src, output req_ready);

endinterface

// File: rtl/bp_core_lce_req_arb_buffer.sv
// Two-entry registered FIFO; the head entry drives the outbound link directly.
module bp_core_lce_req_arb_buffer #(
   parameter int width_p = 1
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] data_i,
   input  logic               v_i,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i,
   output logic               full_o,
   output logic               empty_o
);

   logic [width_p-1:0] mem_r [2];
   logic               wr_ptr_r;
   logic               rd_ptr_r;
   logic [1:0]         count_r;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (v_i)    wr_ptr_r <= ~wr_ptr_r;
         if (yumi_i) rd_ptr_r <= ~rd_ptr_r;
         count_r <= count_r + {1'b0, v_i} - {1'b0, yumi_i};
      end
   end

   // Payload storage carries no reset; validity comes from count_r alone.
   always_ff @(posedge clk_i) begin
      if (v_i) mem_r[wr_ptr_r] <= data_i;
   end

   assign data_o  = mem_r[rd_ptr_r];
   assign full_o  = (count_r == 2'd2);
   assign empty_o = (count_r == 2'd0);

endmodule

// File: rtl/bp_core_lce_req_arbiter.sv
// Round-robin merge of icache (0) and dcache (1) LCE requests with per-requester credits.
module bp_core_lce_req_arbiter
   import bp_core_lce_req_arbiter_pkg::*;
#(
   parameter  int width_p         = 0,
   parameter  int credits_p       = 4,
   localparam int credit_width_lp = $clog2(credits_p + 1)
) (
   input  logic                                    clk_i,
   input  logic                                    reset_n_i,
   input  logic [lce_req_num_gp*width_p-1:0]       req_i,
   input  logic [lce_req_num_gp-1:0]               req_v_i,
   output logic [lce_req_num_gp-1:0]               req_yumi_o,
   bp_core_lce_req_arbiter_if.master               link,
   input  logic [lce_req_num_gp-1:0]               credit_return_v_i,
   output logic [lce_req_num_gp*credit_width_lp-1:0] credit_count_o,
   output logic                                    idle_o
);

   localparam logic [credit_width_lp-1:0] credit_full_lp = credit_width_lp'(credits_p);

   logic [lce_req_num_gp-1:0][credit_width_lp-1:0] credit_r;
   logic                      last_r;
   logic [lce_req_num_gp-1:0] elig;
   logic [lce_req_num_gp-1:0] grant;
   logic                      full;
   logic                      empty;
   logic                      enq;
   logic                      deq;
   logic [width_p:0]          enq_entry;
   logic [width_p:0]          head_entry;

   // Only a slot free at the start of the cycle may be granted, keeping yumi off the ready path.
   always_comb begin
      for (int i = 0; i < lce_req_num_gp; i++)
         elig[i] = req_v_i[i] & (credit_r[i] != '0);
      grant = '0;
      if (reset_n_i && !full) grant = rr_grant(elig, last_r);
   end

   assign req_yumi_o = grant;
   assign enq        = |grant;
   assign enq_entry  = {grant[1], grant[1] ? req_i[2*width_p-1:width_p] : req_i[width_p-1:0]};
   assign deq        = ~empty & link.req_ready;

   bp_core_lce_req_arb_buffer #(.width_p(width_p + 1)) buffer (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .data_i    (enq_entry),
      .v_i       (enq),
      .data_o    (head_entry),
      .yumi_i    (deq),
      .full_o    (full),
      .empty_o   (empty)
   );

   assign link.req     = head_entry[width_p-1:0];
   assign link.req_v   = ~empty;
   assign link.req_src = ~empty & head_entry[width_p];

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         credit_r <= {lce_req_num_gp{credit_full_lp}};
         last_r   <= 1'b1;
      end else begin
         if (enq) last_r <= grant[1];
         for (int i = 0; i < lce_req_num_gp; i++) begin
            case ({grant[i], credit_return_v_i[i]})
               2'b10:   credit_r[i] <= credit_r[i] - 1'b1;
               2'b01:   if (credit_r[i] != credit_full_lp) credit_r[i] <= credit_r[i] + 1'b1;
               default: ;
            endcase
         end
      end
   end

   assign credit_count_o = credit_r;
   assign idle_o = empty & (credit_r[0] == credit_full_lp) & (credit_r[1] == credit_full_lp);

   // A return with nothing outstanding means the responder side lost track of a credit.
   always @(posedge clk_i) begin
      for (int i = 0; i < lce_req_num_gp; i++)
         if (reset_n_i)
            assert (!(credit_return_v_i[i] && !grant[i] && credit_r[i] == credit_full_lp))
               else $warning("lce req arbiter: credit return overflow on requester %0d", i);
   end

endmodule

// File: tb/tb_bp_core_lce_req_arbiter.sv
// Directed bench for the LCE request arbiter with a queue-based reference model.
module tb_bp_core_lce_req_arbiter;

   localparam int W  = 8;
   localparam int C  = 4;
   localparam int CW = 3;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [2*W-1:0]  req;
   logic [1:0]      req_v;
   logic [1:0]      yumi;
   logic [1:0]      ret;
   logic            ready;
   logic [2*CW-1:0] ccount;
   logic            idle;
   logic [7:0]      pay_cnt = 8'd0;

   bp_core_lce_req_arbiter_if #(.width_p(W)) link ();
   assign link.req_ready = ready;

   bp_core_lce_req_arbiter #(.width_p(W), .credits_p(C)) dut (
      .clk_i             (clk),
      .reset_n_i         (reset_n),
      .req_i             (req),
      .req_v_i           (req_v),
      .req_yumi_o        (yumi),
      .link              (link),
      .credit_return_v_i (ret),
      .credit_count_o    (ccount),
      .idle_o            (idle)
   );

   always #5 clk = ~clk;

   // Payloads change every cycle so the buffered order is observable.
   always @(posedge clk) pay_cnt <= pay_cnt + 8'd1;
   assign req = {pay_cnt ^ 8'h5A, pay_cnt};

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: buffer as a queue, credits as integers.
   typedef struct packed {logic src; logic [W-1:0] data;} entry_t;
   entry_t     mq[$];
   int         mcred[2];
   logic       mlast;
   logic [1:0] eg;
   bit         e0, e1;
   entry_t     ment;

   always @(negedge clk) begin
      if (!reset_n) begin
         mq.delete();
         mcred[0] = C;
         mcred[1] = C;
         mlast    = 1'b1;
         check("rst_yumi", yumi, 0);
         check("rst_v", link.req_v, 0);
         check("rst_src", link.req_src, 0);
         check("rst_cc", ccount, {3'(C), 3'(C)});
         check("rst_idle", idle, 1);
      end else begin
         eg = 2'b00;
         if (mq.size() < 2) begin
            e0 = req_v[0] && mcred[0] > 0;
            e1 = req_v[1] && mcred[1] > 0;
            if (e0 && e1) eg = mlast ? 2'b01 : 2'b10;
            else          eg = {e1, e0};
         end
         check("m_yumi", yumi, eg);
         check("m_v", link.req_v, mq.size() > 0);
         if (mq.size() > 0) begin
            check("m_src", link.req_src, mq[0].src);
            check("m_data", link.req, mq[0].data);
         end else begin
            check("m_src_idle", link.req_src, 0);
         end
         check("m_cc0", ccount[CW-1:0], mcred[0]);
         check("m_cc1", ccount[2*CW-1:CW], mcred[1]);
         check("m_idle", idle, mq.size() == 0 && mcred[0] == C && mcred[1] == C);
         if (mq.size() > 0 && ready) void'(mq.pop_front());
         if (eg != 2'b00) begin
            ment.src  = eg[1];
            ment.data = eg[1] ? req[2*W-1:W] : req[W-1:0];
            mq.push_back(ment);
            mlast = eg[1];
         end
         for (int i = 0; i < 2; i++) begin
            mcred[i] = mcred[i] - int'(eg[i]) + int'(ret[i]);
            if (mcred[i] > C) mcred[i] = C;
         end
      end
   end

   logic [1:0]      s_yumi;
   logic            s_v, s_src, s_idle;
   logic [W-1:0]    s_data;
   logic [2*CW-1:0] s_cc;

   task automatic tick(input logic [1:0] v, input logic rdy, input logic [1:0] r);
      req_v = v; ready = rdy; ret = r;
      @(negedge clk);
      s_yumi = yumi; s_v = link.req_v; s_src = link.req_src;
      s_data = link.req; s_cc = ccount; s_idle = idle;
      @(posedge clk); #1;
   endtask

   int         nv, ny;
   logic [1:0] g_first, g_second;
   logic [W-1:0] head;

   initial begin
      reset_n = 1'b0; req_v = 2'b00; ready = 1'b0; ret = 2'b00;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Idle after reset
      tick(2'b00, 1'b1, 2'b00);
      check("init_idle", s_idle, 1);
      check("init_cc", s_cc, {3'd4, 3'd4});
      check("init_v", s_v, 0);

      // Alternation at full rate, returns in phase with grants
      nv = 0;
      for (int k = 0; k < 8; k++) begin
         tick(2'b11, 1'b1, (k < 2) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10));
         if (s_v) begin
            check("alt_src", s_src, nv % 2);
            nv++;
         end
      end
      tick(2'b00, 1'b1, 2'b11);
      if (s_v) begin
         check("alt_src", s_src, nv % 2);
         nv++;
      end
      check("alt_count", nv, 8);
      check("alt_cc", s_cc, {3'd3, 3'd3});
      tick(2'b00, 1'b1, 2'b00);
      check("alt_idle", s_idle, 1);

      // Credit exhaustion on requester 1
      ny = 0;
      for (int k = 0; k < 8; k++) begin
         tick(2'b10, 1'b1, 2'b00);
         ny += int'(s_yumi[1]);
      end
      check("exh_grants", ny, 4);
      check("exh_cc1", ccount[2*CW-1:CW], 0);
      ny = 0;
      tick(2'b10, 1'b1, 2'b10);
      ny += int'(s_yumi[1]);
      for (int k = 0; k < 4; k++) begin
         tick(2'b10, 1'b1, 2'b00);
         ny += int'(s_yumi[1]);
      end
      check("exh_one_more", ny, 1);
      for (int k = 0; k < 4; k++) tick(2'b00, 1'b1, 2'b10);
      check("exh_restore", ccount, {3'd4, 3'd4});

      // Backpressure: two grants fill the buffer, head held
      ny = 0; g_first = 2'b00; g_second = 2'b00; head = '0;
      for (int k = 0; k < 6; k++) begin
         tick(2'b11, 1'b0, 2'b00);
         if (s_yumi != 2'b00) begin
            if (ny == 0) g_first = s_yumi; else g_second = s_yumi;
            ny++;
         end
         if (k == 1) head = s_data;
         if (k >= 1) begin
            check("bp_head_src", s_src, 0);
            check("bp_head_data", s_data, head);
         end
      end
      check("bp_grants", ny, 2);
      check("bp_first", g_first, 2'b01);
      check("bp_second", g_second, 2'b10);
      tick(2'b11, 1'b1, 2'b00);
      check("bp_deq_nogrant", s_yumi, 2'b00);
      tick(2'b11, 1'b0, 2'b00);
      check("bp_next_grant", s_yumi, 2'b01);
      check("bp_new_head", s_src, 1);
      repeat (3) tick(2'b00, 1'b1, 2'b00);
      tick(2'b00, 1'b1, 2'b11);
      tick(2'b00, 1'b1, 2'b01);
      check("bp_restore", ccount, {3'd4, 3'd4});

      // Simultaneous grant and return, then return at full
      tick(2'b01, 1'b1, 2'b00);
      tick(2'b01, 1'b1, 2'b00);
      check("sim_cc_before", ccount[CW-1:0], 2);
      tick(2'b01, 1'b1, 2'b01);
      check("sim_grant", s_yumi, 2'b01);
      check("sim_cc_after", ccount[CW-1:0], 2);
      tick(2'b00, 1'b1, 2'b01);
      tick(2'b00, 1'b1, 2'b01);
      check("sim_cc_full", ccount[CW-1:0], 4);
      tick(2'b00, 1'b1, 2'b01);
      check("sim_cc_sat", ccount[CW-1:0], 4);

      // Idle only after the last return with the buffer drained
      repeat (3) tick(2'b01, 1'b1, 2'b00);
      tick(2'b00, 1'b1, 2'b00);
      tick(2'b00, 1'b1, 2'b00);
      check("drain_busy", s_idle, 0);
      tick(2'b00, 1'b1, 2'b01);
      check("drain_r1", s_idle, 0);
      tick(2'b00, 1'b1, 2'b01);
      check("drain_r2", s_idle, 0);
      tick(2'b00, 1'b1, 2'b01);
      check("drain_r3", s_idle, 0);
      tick(2'b00, 1'b1, 2'b00);
      check("drain_idle", s_idle, 1);

      // Reset with two requester-0 packets buffered (last grant was 0)
      tick(2'b01, 1'b0, 2'b00);
      tick(2'b01, 1'b0, 2'b00);
      req_v = 2'b11;
      check("pre_rst_v", link.req_v, 1);
      reset_n = 1'b0;
      #1;
      check("arst_v", link.req_v, 0);
      check("arst_cc", ccount, {3'd4, 3'd4});
      check("arst_idle", idle, 1);
      check("arst_yumi", yumi, 2'b00);
      @(posedge clk); #1;
      reset_n = 1'b1;
      tick(2'b11, 1'b0, 2'b00);
      check("post_rst_grant", s_yumi, 2'b01);
      tick(2'b00, 1'b1, 2'b00);
      tick(2'b00, 1'b1, 2'b01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
